// File: rtl/uart_sort_pkg.sv
// Shared types and constants for the UART sort sequencer.
// Holds the FSM states, the NAK byte value and the default frame size.
package uart_sort_pkg;

  localparam int MAX_LEN_DEF = 16;
  localparam logic [7:0] NAK_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_FEED,
    S_COLLECT,
    S_TX_LEN,
    S_TX_DATA,
    S_TX_NAK
  } state_e;

endpackage

// File: rtl/uart_sort_sequencer_if.sv
// Byte stream bundle with a valid/ready handshake.
// The master drives data and valid; the slave drives ready.
interface uart_sort_sequencer_if;

  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/sort_buf.sv
// Frame buffer: DEPTH x 8 register array with one write port.
// The read port is combinational and the array has no reset.
module sort_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_sort_sequencer.sv
// Receives a length-prefixed frame, streams it through an external
// sorter, and transmits the sorted frame back (or a NAK on error).
module uart_sort_sequencer
  import uart_sort_pkg::*;
#(
  parameter int MAX_LEN     = MAX_LEN_DEF,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic [7:0] sort_data_o,
  output logic       sort_valid_o,
  output logic       sort_last_o,
  input  logic       sort_ready_i,
  input  logic [7:0] sort_data_i,
  input  logic       sort_valid_i,
  input  logic       sort_last_i,
  output logic       sort_ready_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);
  localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

  state_e        state_q, state_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    len_q, len_d;
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  logic          err_q, err_d;

  logic          buf_we;
  logic [7:0]    buf_wdata;
  logic [7:0]    buf_rdata;
  logic          at_last;
  logic          rx_fire, tx_fire, so_fire, si_fire;

  sort_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (idx_q[AW-1:0]),
    .wdata_i (buf_wdata),
    .raddr_i (idx_q[AW-1:0]),
    .rdata_o (buf_rdata)
  );

  assign at_last = (idx_q == len_q - 8'd1);

  // Outputs are forced quiet while rst_n is low, even before the first edge.
  always_comb begin
    rx_ready_o   = 1'b0;
    tx_valid_o   = 1'b0;
    tx_data_o    = 8'h00;
    sort_valid_o = 1'b0;
    sort_last_o  = 1'b0;
    sort_data_o  = 8'h00;
    sort_ready_o = 1'b0;
    busy_o       = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE:    rx_ready_o = 1'b1;
      S_RECV:    rx_ready_o = 1'b1;
      S_FEED: begin
        sort_valid_o = 1'b1;
        sort_last_o  = at_last;
        sort_data_o  = buf_rdata;
      end
      S_COLLECT: sort_ready_o = 1'b1;
      S_TX_LEN: begin
        tx_valid_o = 1'b1;
        tx_data_o  = len_q;
      end
      S_TX_DATA: begin
        tx_valid_o = 1'b1;
        tx_data_o  = buf_rdata;
      end
      S_TX_NAK: begin
        tx_valid_o = 1'b1;
        tx_data_o  = NAK_BYTE;
      end
      default: ;
    endcase
    if (!rst_n) begin
      rx_ready_o   = 1'b0;
      tx_valid_o   = 1'b0;
      tx_data_o    = 8'h00;
      sort_valid_o = 1'b0;
      sort_last_o  = 1'b0;
      sort_data_o  = 8'h00;
      sort_ready_o = 1'b0;
      busy_o       = 1'b0;
    end
  end

  assign err_o   = err_q & rst_n;
  assign rx_fire = rx_valid_i & rx_ready_o;
  assign tx_fire = tx_valid_o & tx_ready_i;
  assign so_fire = sort_valid_o & sort_ready_i;
  assign si_fire = sort_valid_i & sort_ready_o;
  assign tmo_inc = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    tmo_d     = '0;
    err_d     = 1'b0;
    buf_we    = 1'b0;
    buf_wdata = rx_data_i;
    unique case (state_q)
      S_IDLE: begin
        if (rx_fire && rx_data_i != 8'd0) begin
          if (rx_data_i <= LEN_MAX) begin
            len_d   = rx_data_i;
            idx_d   = 8'd0;
            state_d = S_RECV;
          end else begin
            err_d   = 1'b1;
            state_d = S_TX_NAK;
          end
        end
      end
      S_RECV: begin
        if (rx_fire) begin
          buf_we = 1'b1;
          if (at_last) begin
            idx_d   = 8'd0;
            state_d = S_FEED;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else if (tmo_inc == TMO_MAX) begin
          // Sender went quiet: drop the frame silently.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      S_FEED: begin
        if (so_fire) begin
          if (at_last) begin
            idx_d   = 8'd0;
            state_d = S_COLLECT;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      S_COLLECT: begin
        if (si_fire) begin
          buf_we    = 1'b1;
          buf_wdata = sort_data_i;
          if (sort_last_i && at_last) begin
            idx_d   = 8'd0;
            state_d = S_TX_LEN;
          end else if (sort_last_i || at_last) begin
            err_d   = 1'b1;
            state_d = S_TX_NAK;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      S_TX_LEN: begin
        if (tx_fire) state_d = S_TX_DATA;
      end
      S_TX_DATA: begin
        if (tx_fire) begin
          if (at_last) begin
            idx_d   = 8'd0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      S_TX_NAK: begin
        if (tx_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 8'd0;
      len_q   <= 8'd0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_sort_sequencer.sv
// Directed bench for uart_sort_sequencer: frame table plus
// timeout, tx stall and mid-frame reset sequences.
module tb_uart_sort_sequencer;
  import uart_sort_pkg::*;

  localparam int TMO = 50;

  typedef struct {
    int n_rx;
    logic [16:0][7:0] rx;
    int n_so;
    int n_ret;
    int last_at;
    logic [15:0][7:0] ret;
    int n_tx;
    logic [16:0][7:0] tx;
    int n_err;
    bit rnd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_sort_sequencer_if rx_if ();
  uart_sort_sequencer_if tx_if ();
  uart_sort_sequencer_if so_if ();
  uart_sort_sequencer_if si_if ();
  logic so_last, si_last, busy, err;

  uart_sort_sequencer #(
    .MAX_LEN     (16),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data_i    (rx_if.data),
    .rx_valid_i   (rx_if.valid),
    .rx_ready_o   (rx_if.ready),
    .tx_data_o    (tx_if.data),
    .tx_valid_o   (tx_if.valid),
    .tx_ready_i   (tx_if.ready),
    .sort_data_o  (so_if.data),
    .sort_valid_o (so_if.valid),
    .sort_last_o  (so_last),
    .sort_ready_i (so_if.ready),
    .sort_data_i  (si_if.data),
    .sort_valid_i (si_if.valid),
    .sort_last_i  (si_last),
    .sort_ready_o (si_if.ready),
    .busy_o       (busy),
    .err_o        (err)
  );

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;
  logic [7:0] tx_q [$];
  logic [8:0] so_q [$];
  bit rnd = 0;
  bit hold_tx = 0;
  bit hold_so = 0;
  vec_t vecs [9];

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_if.valid && tx_if.ready) tx_q.push_back(tx_if.data);
      if (so_if.valid && so_if.ready) so_q.push_back({so_last, so_if.data});
      if (err) err_cnt++;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    tx_if.ready = hold_tx ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    so_if.ready = hold_so ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic gap();
    if (rnd) repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rx_send(input logic [7:0] b);
    int n = 0;
    bit ok = 0;
    gap();
    rx_if.data  = b;
    rx_if.valid = 1'b1;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = rx_if.ready;
      @(posedge clk);
      #1;
      n++;
    end
    rx_if.valid = 1'b0;
    if (!ok) check("rx_handshake", 32'(ok), 32'd1);
  endtask

  task automatic sort_ret(input vec_t v);
    for (int i = 0; i < v.n_ret; i++) begin
      int n = 0;
      bit ok = 0;
      gap();
      si_if.data  = v.ret[i];
      si_last     = (i == v.last_at);
      si_if.valid = 1'b1;
      while (!ok && n < 300) begin
        @(negedge clk);
        ok = si_if.ready;
        @(posedge clk);
        #1;
        n++;
      end
      si_if.valid = 1'b0;
      si_last     = 1'b0;
      if (!ok) check("sort_handshake", 32'(ok), 32'd1);
    end
  endtask

  task automatic wait_so(input int cnt);
    int n = 0;
    while (so_q.size() < cnt && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 2000);
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_if.ready), 32'd0);
    check({tag, "_tx_valid"}, 32'(tx_if.valid), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_if.data), 32'd0);
    check({tag, "_so_valid"}, 32'(so_if.valid), 32'd0);
    check({tag, "_so_last"}, 32'(so_last), 32'd0);
    check({tag, "_so_data"}, 32'(so_if.data), 32'd0);
    check({tag, "_si_ready"}, 32'(si_if.ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int e0 = err_cnt;
    string tg = $sformatf("v%0d", id);
    rnd = v.rnd;
    tx_q.delete();
    so_q.delete();
    for (int i = 0; i < v.n_rx; i++) rx_send(v.rx[i]);
    if (v.n_so > 0) begin
      wait_so(v.n_so);
      check({tg, "_so_cnt"}, 32'(so_q.size()), 32'(v.n_so));
      for (int i = 0; i < v.n_so && i < so_q.size(); i++)
        check($sformatf("%s_so%0d", tg, i), 32'(so_q[i]),
              32'({i == v.n_so - 1, v.rx[i+1]}));
    end
    sort_ret(v);
    wait_idle();
    check({tg, "_tx_cnt"}, 32'(tx_q.size()), 32'(v.n_tx));
    for (int i = 0; i < v.n_tx && i < tx_q.size(); i++)
      check($sformatf("%s_tx%0d", tg, i), 32'(tx_q[i]), 32'(v.tx[i]));
    check({tg, "_err"}, 32'(err_cnt - e0), 32'(v.n_err));
    rnd = 0;
  endtask

  function automatic vec_t mk(input int n_rx, input int n_so,
                              input int n_ret, input int last_at,
                              input int n_tx, input int n_err);
    vec_t v;
    v.n_rx = n_rx; v.rx = '0; v.n_so = n_so;
    v.n_ret = n_ret; v.last_at = last_at; v.ret = '0;
    v.n_tx = n_tx; v.tx = '0; v.n_err = n_err; v.rnd = 0;
    return v;
  endfunction

  initial begin
    vec_t st;
    int e0;
    int cnt;
    bit stable;

    rx_if.valid = 1'b0;
    rx_if.data  = 8'h00;
    si_if.valid = 1'b0;
    si_if.data  = 8'h00;
    si_last     = 1'b0;
    tx_if.ready = 1'b1;
    so_if.ready = 1'b1;

    vecs[0] = mk(5, 4, 4, 3, 5, 0);
    vecs[0].rx[4:0]  = {8'h01, 8'h07, 8'h02, 8'h09, 8'h04};
    vecs[0].ret[3:0] = {8'h09, 8'h07, 8'h02, 8'h01};
    vecs[0].tx[4:0]  = {8'h09, 8'h07, 8'h02, 8'h01, 8'h04};
    vecs[1] = mk(1, 0, 0, -1, 1, 1);
    vecs[1].rx[0] = 8'h11;
    vecs[1].tx[0] = NAK_BYTE;
    vecs[2] = mk(2, 1, 1, 0, 2, 0);
    vecs[2].rx[1:0] = {8'h5A, 8'h01};
    vecs[2].ret[0]  = 8'h5A;
    vecs[2].tx[1:0] = {8'h5A, 8'h01};
    vecs[3] = mk(4, 3, 2, 1, 1, 1);
    vecs[3].rx[3:0]  = {8'h20, 8'h10, 8'h30, 8'h03};
    vecs[3].ret[1:0] = {8'h20, 8'h10};
    vecs[3].tx[0]    = NAK_BYTE;
    vecs[4] = mk(3, 2, 2, -1, 1, 1);
    vecs[4].rx[2:0]  = {8'hA0, 8'hB0, 8'h02};
    vecs[4].ret[1:0] = {8'hB0, 8'hA0};
    vecs[4].tx[0]    = NAK_BYTE;
    vecs[5] = mk(1, 0, 0, -1, 0, 0);
    vecs[5].rx[0] = 8'h00;
    vecs[6] = mk(17, 16, 16, 15, 17, 0);
    vecs[6].rx[0] = 8'h10;
    vecs[6].tx[0] = 8'h10;
    for (int i = 1; i <= 16; i++) begin
      vecs[6].rx[i]   = 8'(17 - i);
      vecs[6].ret[i-1] = 8'(i);
      vecs[6].tx[i]   = 8'(i);
    end
    vecs[7] = vecs[0];
    vecs[7].rnd = 1;
    vecs[8] = vecs[6];
    vecs[8].rnd = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rx_ready", 32'(rx_if.ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    for (int k = 0; k < 9; k++) run_vec(vecs[k], k);

    // Timeout: length 3, one payload byte, then silence.
    tx_q.delete();
    e0 = err_cnt;
    rx_send(8'h03);
    rx_send(8'hAA);
    cnt = 0;
    while (!err && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("tmo_cycles", 32'(cnt), 32'(TMO));
    check("tmo_busy", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("tmo_tx_cnt", 32'(tx_q.size()), 32'd0);
    check("tmo_err", 32'(err_cnt - e0), 32'd1);
    run_vec(vecs[2], 20);

    // Tx stall in TX_DATA for 20 clocks.
    st = mk(3, 2, 2, 1, 3, 0);
    st.rx[2:0]  = {8'h3C, 8'hC3, 8'h02};
    st.ret[1:0] = {8'hC3, 8'h3C};
    tx_q.delete();
    so_q.delete();
    for (int i = 0; i < 3; i++) rx_send(st.rx[i]);
    wait_so(2);
    sort_ret(st);
    #1;
    cnt = 0;
    while (tx_q.size() < 1 && cnt < 100) begin
      @(posedge clk);
      #2;
      cnt++;
    end
    hold_tx = 1;
    tx_if.ready = 1'b0;
    stable = 1;
    repeat (20) begin
      @(negedge clk);
      if (!(tx_if.valid === 1'b1 && tx_if.data === 8'h3C)) stable = 0;
    end
    check("stall_stable", 32'(stable), 32'd1);
    check("stall_tx_cnt", 32'(tx_q.size()), 32'd1);
    @(posedge clk);
    #1;
    hold_tx = 0;
    wait_idle();
    check("stall_tx_total", 32'(tx_q.size()), 32'd3);
    if (tx_q.size() == 3)
      check("stall_tx_order", {8'h0, tx_q[0], tx_q[1], tx_q[2]},
            32'h00023CC3);

    // Reset while FEED is stalled by the sorter.
    hold_so = 1;
    tx_q.delete();
    e0 = err_cnt;
    rx_send(8'h03);
    rx_send(8'h11);
    rx_send(8'h22);
    rx_send(8'h33);
    @(negedge clk);
    check("feed_busy", 32'(busy), 32'd1);
    check("feed_so_valid", 32'(so_if.valid), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("feed_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold_so = 0;
    @(negedge clk);
    check("feed_post_rx_ready", 32'(rx_if.ready), 32'd1);
    check("feed_post_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("feed_no_tx", 32'(tx_q.size()), 32'd0);
    check("feed_no_err", 32'(err_cnt - e0), 32'd0);
    run_vec(vecs[0], 30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
